// File: rtl/kbd_pkg.sv
// Shared defaults, pointer-width helper and head-output layout for the keyboard FIFO.
package kbd_pkg;

  localparam int DATA_W_DEF = 7;
  localparam int DEPTH_DEF  = 8;
  localparam int DROP_W_DEF = 8;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  typedef struct packed {
    logic                  strb;
    logic [DATA_W_DEF-1:0] code;
  } head_t;

endpackage

// File: rtl/kbd_fifo_if.sv
// Bus between the key producer / CPU decode side (master) and the keyboard FIFO (slave).
interface kbd_fifo_if #(
  parameter int DATA_W = 7,
  parameter int DEPTH  = 8,
  parameter int DROP_W = 8
);
  logic [DATA_W-1:0]      wr_data;
  logic                   wr_strb;
  logic                   clr;
  logic                   flush;
  logic [DATA_W:0]        kbd;
  logic                   kbd_strb;
  logic [$clog2(DEPTH):0] count;
  logic                   full;
  logic                   ovf;
  logic [DROP_W-1:0]      drop_cnt;

  modport master (
    output wr_data, wr_strb, clr, flush,
    input  kbd, kbd_strb, count, full, ovf, drop_cnt
  );

  modport slave (
    input  wr_data, wr_strb, clr, flush,
    output kbd, kbd_strb, count, full, ovf, drop_cnt
  );
endinterface

// File: rtl/kbd_fifo_rise_detect.sv
// One-cycle pulse on a rising edge of d; a level already high when reset releases is not an edge.
module rise_detect (
  input  logic clock,
  input  logic res,
  input  logic d,
  output logic q_pulse
);
  logic d_q;
  logic armed;

  always_ff @(posedge clock or posedge res) begin
    if (res) begin
      d_q   <= 1'b0;
      armed <= 1'b0;
    end else begin
      d_q   <= d;
      armed <= 1'b1;
    end
  end

  assign q_pulse = d & ~d_q & armed;
endmodule

// File: rtl/kbd_fifo.sv
// Keyboard code FIFO between ps2ctrlr and address_decode; head presented with strobe in the MSB.
module kbd_fifo
  import kbd_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int DROP_W   = DROP_W_DEF,
  parameter int EDGE_POP = 1
) (
  input logic       clock,
  input logic       res,
  kbd_fifo_if.slave bus
);
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [1:0]        rst_sync;
  logic              rst_int;
  logic              push_ev, pop_ev;
  logic              do_push, do_pop;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic [CW-1:0]     count_q, count_n;
  logic              ovf_q, ovf_n, full_q, strb_q;
  logic [DROP_W-1:0] drop_q, drop_n;
  logic [DATA_W-1:0] code_q, code_n;

  // Assert immediately, release only on a clock edge.
  always_ff @(posedge clock or posedge res) begin
    if (res) rst_sync <= 2'b11;
    else     rst_sync <= {rst_sync[0], 1'b0};
  end
  assign rst_int = rst_sync[1];

  rise_detect u_push_det (.clock(clock), .res(rst_int), .d(bus.wr_strb), .q_pulse(push_ev));

  generate
    if (EDGE_POP != 0) begin : g_pop_edge
      rise_detect u_pop_det (.clock(clock), .res(rst_int), .d(bus.clr), .q_pulse(pop_ev));
    end else begin : g_pop_level
      assign pop_ev = bus.clr;
    end
  endgenerate

  always_comb begin
    wr_ptr_n = wr_ptr;
    rd_ptr_n = rd_ptr;
    count_n  = count_q;
    ovf_n    = ovf_q;
    drop_n   = drop_q;
    do_pop   = 1'b0;
    do_push  = 1'b0;
    code_n   = '0;
    if (bus.flush) begin
      wr_ptr_n = '0;
      rd_ptr_n = '0;
      count_n  = '0;
      ovf_n    = 1'b0;
      drop_n   = '0;
    end else begin
      do_pop  = pop_ev && (count_q != '0);
      // A same-cycle pop frees the slot a full FIFO needs for the push.
      do_push = push_ev && ((count_q != FULL_CNT) || do_pop);
      if (do_pop)  rd_ptr_n = rd_ptr + PW'(1);
      if (do_push) wr_ptr_n = wr_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_n = count_q + CW'(1);
        2'b01:   count_n = count_q - CW'(1);
        default: count_n = count_q;
      endcase
      if (push_ev && !do_push) begin
        ovf_n = 1'b1;
        if (drop_q != '1) drop_n = drop_q + DROP_W'(1);
      end
    end
    // The new head may be the code being written this very cycle.
    if (count_n == '0)                      code_n = '0;
    else if (do_push && rd_ptr_n == wr_ptr) code_n = bus.wr_data;
    else                                    code_n = mem[rd_ptr_n];
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= bus.wr_data;
  end

  always_ff @(posedge clock or posedge rst_int) begin
    if (rst_int) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
      full_q  <= 1'b0;
      strb_q  <= 1'b0;
      code_q  <= '0;
    end else begin
      wr_ptr  <= wr_ptr_n;
      rd_ptr  <= rd_ptr_n;
      count_q <= count_n;
      ovf_q   <= ovf_n;
      drop_q  <= drop_n;
      full_q  <= (count_n == FULL_CNT);
      strb_q  <= (count_n != '0);
      code_q  <= code_n;
    end
  end

  assign bus.kbd      = {strb_q, code_q};
  assign bus.kbd_strb = strb_q;
  assign bus.count    = count_q;
  assign bus.full     = full_q;
  assign bus.ovf      = ovf_q;
  assign bus.drop_cnt = drop_q;
endmodule

// File: tb/tb_kbd_fifo.sv
// Directed bench for kbd_fifo at default parameters (7-bit codes, 8 entries, edge pop).
module tb_kbd_fifo;
  import kbd_pkg::*;

  logic clock = 1'b0;
  logic res   = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  kbd_fifo_if #(.DATA_W(7), .DEPTH(8), .DROP_W(8)) bus ();

  kbd_fifo #(.DATA_W(7), .DEPTH(8), .DROP_W(8), .EDGE_POP(1)) dut (
    .clock(clock),
    .res  (res),
    .bus  (bus.slave)
  );

  always #10 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] head(input logic [6:0] code);
    head_t h;
    h.strb = 1'b1;
    h.code = code;
    return 32'(h);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [6:0] code);
    bus.wr_data = code;
    bus.wr_strb = 1'b1;
    tick();
    bus.wr_strb = 1'b0;
    tick();
  endtask

  task automatic pop();
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    tick();
  endtask

  initial begin
    bus.wr_data = '0;
    bus.wr_strb = 1'b0;
    bus.clr     = 1'b0;
    bus.flush   = 1'b0;
    #1;
    chk("rst_kbd_during", bus.kbd, 0);
    chk("rst_count_during", bus.count, 0);
    #30 res = 1'b0;
    repeat (3) tick();
    chk("rst_kbd", bus.kbd, 0);
    chk("rst_strb", bus.kbd_strb, 0);
    chk("rst_full", bus.full, 0);
    chk("rst_ovf", bus.ovf, 0);
    chk("rst_drop", bus.drop_cnt, 0);

    // Level held three cycles pushes once.
    bus.wr_data = 7'h41;
    bus.wr_strb = 1'b1;
    tick();
    chk("first_kbd", bus.kbd, 32'hC1);
    chk("first_strb", bus.kbd_strb, 1);
    chk("first_count", bus.count, 1);
    tick();
    tick();
    chk("held_count", bus.count, 1);
    bus.wr_strb = 1'b0;
    tick();

    push(7'h42);
    push(7'h43);
    chk("abc_count", bus.count, 3);
    chk("abc_kbd", bus.kbd, 32'hC1);
    for (int i = 0; i < 4; i++) begin
      bus.clr = 1'b1;
      repeat (4) tick();
      bus.clr = 1'b0;
      tick();
      chk($sformatf("clr%0d_kbd", i), bus.kbd, (i < 2) ? head(7'(8'h42 + i)) : 32'h0);
      chk($sformatf("clr%0d_count", i), bus.count, (i < 3) ? 32'(2 - i) : 32'h0);
    end

    // Overflow: ten pushes into eight slots.
    for (int i = 0; i < 10; i++) push(7'(8'h10 + i));
    chk("ovf_count", bus.count, 8);
    chk("ovf_full", bus.full, 1);
    chk("ovf_flag", bus.ovf, 1);
    chk("ovf_drop", bus.drop_cnt, 2);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("ovf_head%0d", i), bus.kbd, head(7'(8'h10 + i)));
      pop();
    end
    chk("ovf_empty_kbd", bus.kbd, 0);
    chk("ovf_empty_count", bus.count, 0);
    chk("ovf_empty_full", bus.full, 0);

    // Simultaneous push and pop while full.
    for (int i = 0; i < 8; i++) push(7'(8'h20 + i));
    chk("sim_full", bus.full, 1);
    bus.wr_data = 7'h30;
    bus.wr_strb = 1'b1;
    bus.clr     = 1'b1;
    tick();
    chk("sim_count", bus.count, 8);
    chk("sim_drop", bus.drop_cnt, 2);
    chk("sim_kbd", bus.kbd, head(7'h21));
    bus.wr_strb = 1'b0;
    bus.clr     = 1'b0;
    tick();
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("sim_head%0d", i), bus.kbd, head(7'(8'h21 + i)));
      pop();
    end
    chk("sim_last", bus.kbd, head(7'h30));
    pop();
    chk("sim_empty", bus.count, 0);

    // Flush beats a concurrent push.
    push(7'h51);
    push(7'h52);
    push(7'h53);
    chk("fl_pre_ovf", bus.ovf, 1);
    chk("fl_pre_count", bus.count, 3);
    bus.flush   = 1'b1;
    bus.wr_data = 7'h54;
    bus.wr_strb = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("fl_count", bus.count, 0);
    chk("fl_kbd", bus.kbd, 0);
    chk("fl_ovf", bus.ovf, 0);
    chk("fl_drop", bus.drop_cnt, 0);
    bus.wr_strb = 1'b0;
    tick();
    chk("fl_nostore", bus.count, 0);

    // Asynchronous reset mid-operation.
    for (int i = 0; i < 5; i++) push(7'(8'h61 + i));
    chk("ar_pre_count", bus.count, 5);
    bus.wr_data = 7'h66;
    bus.wr_strb = 1'b1;
    #5 res = 1'b1;
    #1;
    chk("ar_kbd", bus.kbd, 0);
    chk("ar_count", bus.count, 0);
    chk("ar_strb", bus.kbd_strb, 0);
    tick();
    tick();
    res = 1'b0;
    repeat (5) tick();
    chk("ar_nopush", bus.count, 0);
    chk("ar_nopush_kbd", bus.kbd, 0);
    bus.wr_strb = 1'b0;
    tick();
    bus.wr_strb = 1'b1;
    tick();
    chk("ar_repush_count", bus.count, 1);
    chk("ar_repush_kbd", bus.kbd, head(7'h66));
    bus.wr_strb = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/kbd_fifo.md
Name: kbd_fifo

Overview:
Parametrised successor to the single-register keyboard latch between ps2ctrlr and address_decode.
- Buffers up to DEPTH key codes in a FIFO.
- Presents the oldest code with an Apple-style strobe in the MSB.
- Pops on the CPU clear access.
- Counts dropped keys on overflow.
- Runs on the 50 MHz FPGA clock. Sits between ps2ctrlr (producer) and address_decode (consumer).

Parameters:
DATA_W, 7, key code width in bits (ASCII = 7).
DEPTH, 8, FIFO entries; power of two, 2..64.
DROP_W, 8, width of saturating dropped-key counter.
EDGE_POP, 1, 1: pop on rising edge of clr; 0: pop every cycle clr is high.

Ports:
clock  in  1  FPGA clock (clock_50 domain).
res  in  1  asynchronous active-high reset.
wr_data  in  DATA_W  key code from ps2ctrlr.
wr_strb  in  1  key-available level from ps2ctrlr; push on its rising edge.
clr  in  1  CPU access to keyboard-clear address; pop per EDGE_POP.
flush  in  1  synchronous empty; higher priority than push and pop.
kbd  out  DATA_W+1  {not_empty, head code}; head bits are 0 when empty.
kbd_strb  out  1  not_empty; equals kbd[DATA_W].
count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
full  out  1  count == DEPTH.
ovf  out  1  sticky: at least one key dropped since reset or flush.
drop_cnt  out  DROP_W  dropped keys, saturating at all-ones.

Behaviour:
- Reset (async assert, release synchronised to clock): all outputs 0, wr/rd pointers 0, edge-detect history regs 0. A wr_strb held high through reset release does not push.
- Edge detect: push_ev = wr_strb & ~wr_strb_q. pop_ev = clr & ~clr_q when EDGE_POP=1, else clr. History regs update every cycle.
- Storage: DEPTH x DATA_W register array. Pointers are $clog2(DEPTH) bits and wrap naturally DEPTH-1 -> 0. count is tracked separately.
- Priority per cycle: flush, then pop, then push.
  - flush: pointers and count go to 0. ovf and drop_cnt clear. Any same-cycle push/pop is discarded.
  - pop_ev when count == 0: ignored; no underflow, no state change.
  - push_ev when count < DEPTH: write at wr_ptr, wr_ptr+1, count+1.
  - push_ev and pop_ev both when 0 < count < DEPTH: write and read together; count unchanged.
  - push_ev and pop_ev both when full: the pop frees a slot, so the push succeeds; count stays DEPTH; no drop.
  - push_ev and pop_ev both when empty: push succeeds, pop ignored; count -> 1.
  - push_ev when full with no pop_ev: code discarded; ovf <= 1; drop_cnt increments unless all-ones.
- Output latency: all outputs are registered.
  - A push into an empty FIFO at edge n makes kbd/kbd_strb valid after edge n (visible in cycle n+1).
  - A pop at edge n shows the next head, or 0 if the FIFO went empty, in cycle n+1.
  - kbd holds steady while no pop occurs, so multi-cycle CPU reads at mem_phi see a stable value.
- count, full and kbd_strb are mutually consistent in every cycle.
- Reset asserted mid-operation aborts everything immediately; contents are lost.

Decomposition:
- Package kbd_pkg: default DATA_W/DEPTH/DROP_W constants; function ptr_w(depth) = $clog2(depth); the typedef of the head-output struct {logic strb; logic [DATA_W-1:0] code}.
- Sub-module rise_detect (clock, res, d, q_pulse): one-cycle pulse on the rising edge of d. Instantiate it for wr_strb and, when EDGE_POP=1, for clr.
- Storage and pointer logic stay in kbd_fifo.

Test Plan:
- Reset, then wr_data=7'h41 with wr_strb high for 3 cycles -> exactly one push. Cycle after the edge: kbd=8'hC1, kbd_strb=1, count=1.
- Push 'A','B','C' (0x41,0x42,0x43); hold clr high for 4 cycles, three times -> kbd sequence 0xC1, 0xC2, 0xC3, 0x00; count 3, 2, 1, 0. A fourth clr on empty leaves count=0.
- DEPTH=8: push 10 distinct codes with no pops -> count=8, full=1, ovf=1, drop_cnt=2. Pops return the first 8 codes in order.
- Full FIFO with push_ev and pop_ev in the same cycle -> count stays 8, drop_cnt unchanged. The new code appears last after 8 pops.
- Three codes queued, ovf=1; pulse flush together with wr_strb rising -> count=0, kbd=0, ovf=0, drop_cnt=0. The concurrent push is not stored.
- Assert res while count=5 and wr_strb is rising -> all outputs 0 asynchronously. After release with wr_strb still high, no push occurs until wr_strb falls and rises again.
